// File: rtl/mdu_pkg.sv
// Shared types and constants for the MDU multiply sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mdu_pkg;

   // Operation encoding as it arrives from the MDU decode stage.
   typedef enum logic [1:0] {
      MUL    = 2'b00,
      MULH   = 2'b01,
      MULHSU = 2'b10,
      MULHU  = 2'b11
   } mul_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      SIGN = 2'b10,
      DONE = 2'b11
   } mul_state_t;

   // Accept cycle to first out_valid cycle, and byte-pair iterations.
   localparam int MUL_LATENCY = 18;
   localparam int MUL_ITERS   = 16;

   // Two's-complement magnitude when the operand is treated as negative.
   // 0x80000000 maps onto itself, which is exactly the unsigned magnitude.
   function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
      return neg ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/mdu_mul_seq_wallace.sv
// 8x8 unsigned Wallace-tree multiplier (partial products reduced by 3:2 CSAs).
// Latency: combinational. Backpressure: none.
// Ports: a_i/b_i 8-bit operands, prod_o 16-bit product.
module mdu_mul_seq_wallace (
   input  logic [7:0]  a_i,
   input  logic [7:0]  b_i,
   output logic [15:0] prod_o
);

   logic [15:0] pp [8];

   always_comb begin
      for (int i = 0; i < 8; i++) begin
         pp[i] = b_i[i] ? ({8'h00, a_i} << i) : 16'h0000;
      end
   end

   // 3:2 compressor on whole rows; returns {carry, sum}. The product fits in
   // 16 bits, so carries falling off the top are always zero.
   function automatic logic [31:0] csa(input logic [15:0] x, input logic [15:0] y,
                                       input logic [15:0] z);
      logic [15:0] s;
      logic [15:0] c;
      s = x ^ y ^ z;
      c = ((x & y) | (x & z) | (y & z)) << 1;
      return {c, s};
   endfunction

   logic [31:0] l1_0, l1_1, l2_0, l2_1, l3_0, l4_0;

   // Level 1: 8 rows -> 6 rows
   assign l1_0 = csa(pp[0], pp[1], pp[2]);
   assign l1_1 = csa(pp[3], pp[4], pp[5]);
   // Level 2: 6 rows -> 4 rows
   assign l2_0 = csa(l1_0[15:0], l1_0[31:16], l1_1[15:0]);
   assign l2_1 = csa(l1_1[31:16], pp[6], pp[7]);
   // Level 3: 4 rows -> 3 rows
   assign l3_0 = csa(l2_0[15:0], l2_0[31:16], l2_1[15:0]);
   // Level 4: 3 rows -> 2 rows
   assign l4_0 = csa(l3_0[15:0], l3_0[31:16], l2_1[31:16]);

   assign prod_o = l4_0[15:0] + l4_0[31:16];

endmodule

// File: rtl/mdu_mul_seq.sv
// Iterative 32x32 multiplier (MUL/MULH/MULHSU/MULHU), one 8x8 byte pair per cycle.
// Latency: 18 cycles accept-to-out_valid; one operation in flight.
// Backpressure: result held stable in DONE until out_ready; in_ready low while busy.
// Ports: clk/rst (sync, active-high), flush, in_* request handshake with op/a/b/tag,
//        out_* result handshake with 32-bit result and tag.
module mdu_mul_seq
   import mdu_pkg::*;
#(
   parameter int TAG_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [31:0]      in_a,
   input  logic [31:0]      in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_result,
   output logic [TAG_W-1:0] out_tag
);

   mul_state_t       state_q, state_d;
   logic [31:0]      a_mag_q, a_mag_d;
   logic [31:0]      b_mag_q, b_mag_d;
   logic             neg_q, neg_d;
   mul_op_t          op_q, op_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [63:0]      acc_q, acc_d;
   logic [3:0]       cnt_q, cnt_d;

   mul_op_t          op_in;
   logic             sa, sb;
   logic             accept;
   logic [1:0]       ia, ib;
   logic [5:0]       shamt;
   logic [7:0]       mul_a, mul_b;
   logic [15:0]      prod;

   assign op_in  = mul_op_t'(in_op);
   assign accept = in_valid & in_ready;

   // MUL's low half does not depend on signedness, so it runs unsigned.
   assign sa = ((op_in == MULH) || (op_in == MULHSU)) & in_a[31];
   assign sb = (op_in == MULH) & in_b[31];

   // cnt walks a-byte in the upper bits, b-byte in the lower bits.
   assign ia    = cnt_q[3:2];
   assign ib    = cnt_q[1:0];
   assign shamt = {({1'b0, ia} + {1'b0, ib}), 3'b000};
   assign mul_a = a_mag_q[{ia, 3'b000} +: 8];
   assign mul_b = b_mag_q[{ib, 3'b000} +: 8];

   mdu_mul_seq_wallace u_wallace (
      .a_i    (mul_a),
      .b_i    (mul_b),
      .prod_o (prod)
   );

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: if (in_valid) state_d = CALC;
            CALC: if (cnt_q == 4'(MUL_ITERS - 1)) state_d = SIGN;
            SIGN: state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      in_ready   = (state_q == IDLE) && !flush;
      out_valid  = (state_q == DONE);
      out_result = (op_q == MUL) ? acc_q[31:0] : acc_q[63:32];
      out_tag    = tag_q;
   end

   // ---------------- Datapath next state ----------------
   always_comb begin
      a_mag_d = a_mag_q;
      b_mag_d = b_mag_q;
      neg_d   = neg_q;
      op_d    = op_q;
      tag_d   = tag_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               a_mag_d = mag32(in_a, sa);
               b_mag_d = mag32(in_b, sb);
               neg_d   = sa ^ sb;
               op_d    = op_in;
               tag_d   = in_tag;
               acc_d   = '0;
               cnt_d   = '0;
            end
         end
         CALC: begin
            // Max shift is 48; the full sum of all 16 terms stays below 2^64.
            acc_d = acc_q + ({48'h0, prod} << shamt);
            cnt_d = cnt_q + 4'd1;
         end
         SIGN: begin
            // Negating zero yields zero, so no spurious sign appears.
            if (neg_q) acc_d = ~acc_q + 64'd1;
         end
         default: ;
      endcase
   end

   // ---------------- Datapath registers ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         a_mag_q <= '0;
         b_mag_q <= '0;
         neg_q   <= 1'b0;
         op_q    <= MUL;
         tag_q   <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else begin
         a_mag_q <= a_mag_d;
         b_mag_q <= b_mag_d;
         neg_q   <= neg_d;
         op_q    <= op_d;
         tag_q   <= tag_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_mdu_mul_seq.sv
// Self-checking bench for mdu_mul_seq: directed table, random ops vs model,
// and hand-written backpressure / flush / reset sequences.
module tb_mdu_mul_seq;
   import mdu_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  in_op = 2'b00;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic [5:0]  in_tag = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_result;
   logic [5:0]  out_tag;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mdu_mul_seq #(.TAG_W(6)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_tag     (in_tag),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_tag    (out_tag)
   );

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [5:0]  tag;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Reference: full 64-bit product of the operands extended per RISC-V rules.
   function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [63:0] xa, xb, p;
      xa = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'h0, a};
      xb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'h0, b};
      p  = xa * xb;
      return (op == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   // Present a request and return right after the accepting posedge.
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] tag);
      int waited = 0;
      @(negedge clk);
      in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
      #1;
      while (!in_ready && waited < 50) begin
         @(negedge clk);
         #1;
         waited++;
      end
      if (!in_ready) check("accept_timeout", in_ready, 1);
      @(posedge clk);
   endtask

   // Wait for the result (bounded), hold out_ready low 'hold' cycles, then handshake.
   task automatic wait_result(input int hold, output logic [31:0] res, output logic [5:0] rtag,
                              output int lat);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      res  = out_result;
      rtag = out_tag;
      if (out_valid) begin
         repeat (hold) @(negedge clk);
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
      end
   endtask

   task automatic watch_no_valid(input string nm, input int cycles);
      int seen = 0;
      repeat (cycles) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check(nm, seen, 0);
   endtask

   initial begin
      logic [31:0] res;
      logic [5:0]  rtag;
      int          lat;

      vecs[0]  = '{2'b00, 32'd7,         32'd6,         6'd5,  32'h0000002A};
      vecs[1]  = '{2'b11, 32'hFFFFFFFF,  32'hFFFFFFFF,  6'd1,  32'hFFFFFFFE};
      vecs[2]  = '{2'b00, 32'hFFFFFFFF,  32'hFFFFFFFF,  6'd2,  32'h00000001};
      vecs[3]  = '{2'b01, 32'h80000000,  32'h80000000,  6'd3,  32'h40000000};
      vecs[4]  = '{2'b01, 32'hFFFFFFFF,  32'h00000003,  6'd4,  32'hFFFFFFFF};
      vecs[5]  = '{2'b10, 32'hFFFFFFFF,  32'hFFFFFFFF,  6'd6,  32'hFFFFFFFF};
      vecs[6]  = '{2'b00, 32'h12345678,  32'h00000010,  6'd7,  32'h23456780};
      vecs[7]  = '{2'b01, 32'h00000000,  32'h80000000,  6'd8,  32'h00000000};
      vecs[8]  = '{2'b10, 32'h80000000,  32'h00000000,  6'd9,  32'h00000000};
      vecs[9]  = '{2'b01, 32'hFFFFFFFF,  32'hFFFFFFFF,  6'd10, 32'h00000000};
      vecs[10] = '{2'b11, 32'h80000000,  32'h00000002,  6'd11, 32'h00000001};
      vecs[11] = '{2'b01, 32'h00000007,  32'hFFFFFFFE,  6'd63, 32'hFFFFFFFF};

      // Reset state
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset_out_valid", out_valid, 0);
      check("reset_in_ready", in_ready, 1);
      check("reset_out_result", out_result, 0);
      check("reset_out_tag", out_tag, 0);

      // Directed table
      for (int i = 0; i < 12; i++) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
         wait_result(0, res, rtag, lat);
         check($sformatf("vec%0d_result", i), res, vecs[i].exp);
         check($sformatf("vec%0d_tag", i), rtag, vecs[i].tag);
         check($sformatf("vec%0d_latency", i), lat, MUL_LATENCY);
      end

      // Random operations against the reference model
      for (int i = 0; i < 60; i++) begin
         logic [1:0]  op;
         logic [31:0] a, b;
         logic [5:0]  tag;
         op  = 2'($urandom_range(0, 3));
         a   = $urandom;
         b   = $urandom;
         tag = 6'($urandom);
         case ($urandom_range(0, 7))
            0: a = 32'h80000000;
            1: b = 32'hFFFFFFFF;
            2: a = 32'h0;
            default: ;
         endcase
         issue(op, a, b, tag);
         wait_result(int'($urandom_range(0, 3)), res, rtag, lat);
         check($sformatf("rand%0d_result", i), res, ref_mul(op, a, b));
         check($sformatf("rand%0d_tag", i), rtag, tag);
         check($sformatf("rand%0d_latency", i), lat, MUL_LATENCY);
      end

      // Backpressure: hold result 10 cycles while a new request is pending
      issue(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd9);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      check("bp_latency", lat, MUL_LATENCY);
      in_valid = 1'b1; in_op = 2'b00; in_a = 32'd3; in_b = 32'd4; in_tag = 6'd12;
      for (int k = 0; k < 10; k++) begin
         #1;
         check($sformatf("bp%0d_out_valid", k), out_valid, 1);
         check($sformatf("bp%0d_out_result", k), out_result, 32'hFFFFFFFE);
         check($sformatf("bp%0d_out_tag", k), out_tag, 6'd9);
         check($sformatf("bp%0d_in_ready", k), in_ready, 0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      #1;
      check("bp_release_out_valid", out_valid, 0);
      check("bp_release_in_ready", in_ready, 1);
      @(posedge clk);
      wait_result(0, res, rtag, lat);
      check("bp_next_result", res, 32'd12);
      check("bp_next_tag", rtag, 6'd12);
      check("bp_next_latency", lat, MUL_LATENCY);

      // Flush at CALC cnt=7 (8th cycle after accept)
      issue(2'b01, 32'hDEADBEEF, 32'h12345678, 6'd20);
      repeat (8) @(negedge clk);
      in_valid = 1'b0;
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #1;
      check("flush_out_valid", out_valid, 0);
      check("flush_in_ready", in_ready, 1);
      watch_no_valid("flush_no_result", 25);
      issue(2'b00, 32'h12345678, 32'h00000010, 6'd21);
      wait_result(0, res, rtag, lat);
      check("post_flush_result", res, 32'h23456780);
      check("post_flush_tag", rtag, 6'd21);
      check("post_flush_latency", lat, MUL_LATENCY);

      // Flush concurrent with a request in IDLE
      @(negedge clk);
      in_valid = 1'b1; in_op = 2'b00; in_a = 32'd5; in_b = 32'd5; in_tag = 6'd3;
      flush = 1'b1;
      #1;
      check("flush_idle_in_ready", in_ready, 0);
      @(negedge clk);
      in_valid = 1'b0;
      flush = 1'b0;
      watch_no_valid("flush_idle_no_result", 25);

      // Reset while DONE
      issue(2'b11, 32'h80000000, 32'h00000004, 6'd33);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      check("rst_done_valid", out_valid, 1);
      check("rst_done_result", out_result, 32'd2);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_result", out_result, 0);
      check("rst_out_tag", out_tag, 0);
      check("rst_in_ready", in_ready, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
